// File: rtl/npu_pkg.sv
// Shared definitions for the NPU layer engine: op codes and flat-vector packing helpers.
package npu_pkg;

  typedef enum logic [1:0] {
    OP_CONV = 2'd0,
    OP_POOL = 2'd1,
    OP_FC   = 2'd2,
    OP_RSV  = 2'd3
  } op_e;

  // Row-major element number; multiply by element width for the bit offset.
  function automatic int unsigned elem_idx(input int unsigned r, input int unsigned c,
                                           input int unsigned w);
    return r * w + c;
  endfunction

endpackage

// File: rtl/npu_dot.sv
// Signed N-term dot product plus sign-extended bias, wrapped to OW bits.
module npu_dot #(
  parameter int N  = 25,
  parameter int BW = 8,
  parameter int OW = 16
) (
  input  logic [N*BW-1:0] a,
  input  logic [N*BW-1:0] b,
  input  logic [BW-1:0]   bias,
  output logic [OW-1:0]   y
);

  // Wide enough that the full-precision sum never overflows before truncation.
  localparam int AW = 2 * BW + $clog2(N + 1) + 1;

  logic signed [AW-1:0] acc;

  always_comb begin
    acc = AW'($signed(bias));
    for (int unsigned i = 0; i < N; i++) begin
      acc = acc + AW'($signed(a[i*BW +: BW]) * $signed(b[i*BW +: BW]));
    end
  end

  assign y = acc[OW-1:0];

endmodule

// File: rtl/npu_layer_engine.sv
// CNN layer datapath: valid convolution, 2x2 max pooling and fully-connected layer,
// each computed combinationally and captured into its own result register on start_i.
module npu_layer_engine
  import npu_pkg::*;
#(
  parameter int BW     = 8,
  parameter int IMG_H  = 32,
  parameter int IMG_W  = 32,
  parameter int K      = 5,
  parameter int P_H    = 28,
  parameter int P_W    = 28,
  parameter int PBW    = 16,
  parameter int FC_LEN = 25,
  parameter int FC_OUT = 10
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        start_i,
  input  logic [1:0]                                  op_i,
  input  logic [IMG_H*IMG_W*BW-1:0]                   conv_img_i,
  input  logic [K*K*BW-1:0]                           conv_w_i,
  input  logic [BW-1:0]                               conv_b_i,
  input  logic [P_H*P_W*PBW-1:0]                      pool_img_i,
  input  logic [FC_LEN*BW-1:0]                        fc_x_i,
  input  logic [FC_OUT*FC_LEN*BW-1:0]                 fc_w_i,
  input  logic [FC_OUT*BW-1:0]                        fc_b_i,
  output logic [(IMG_H-K+1)*(IMG_W-K+1)*2*BW-1:0]     conv_o,
  output logic [(P_H/2)*(P_W/2)*PBW-1:0]              pool_o,
  output logic [FC_OUT*2*BW-1:0]                      fc_o,
  output logic                                        valid_o
);

  localparam int OH = IMG_H - K + 1;
  localparam int OW = IMG_W - K + 1;

  logic [OH*OW*2*BW-1:0]          conv_d;
  logic [(P_H/2)*(P_W/2)*PBW-1:0] pool_d;
  logic [FC_OUT*2*BW-1:0]         fc_d;

  // Each output pixel gathers its KxK window into filter order, so it lines up with conv_w_i.
  for (genvar r = 0; r < OH; r++) begin : g_conv_r
    for (genvar c = 0; c < OW; c++) begin : g_conv_c
      logic [K*K*BW-1:0] win;
      for (genvar i = 0; i < K; i++) begin : g_i
        for (genvar j = 0; j < K; j++) begin : g_j
          assign win[elem_idx(i, j, K)*BW +: BW] =
            conv_img_i[elem_idx(r + i, c + j, IMG_W)*BW +: BW];
        end
      end
      npu_dot #(.N(K * K), .BW(BW), .OW(2 * BW)) u_dot (
        .a   (win),
        .b   (conv_w_i),
        .bias(conv_b_i),
        .y   (conv_d[elem_idx(r, c, OW)*2*BW +: 2*BW])
      );
    end
  end

  for (genvar pr = 0; pr < P_H / 2; pr++) begin : g_pool_r
    for (genvar pc = 0; pc < P_W / 2; pc++) begin : g_pool_c
      logic signed [PBW-1:0] e00, e01, e10, e11, m0, m1;
      assign e00 = pool_img_i[elem_idx(2*pr,     2*pc,     P_W)*PBW +: PBW];
      assign e01 = pool_img_i[elem_idx(2*pr,     2*pc + 1, P_W)*PBW +: PBW];
      assign e10 = pool_img_i[elem_idx(2*pr + 1, 2*pc,     P_W)*PBW +: PBW];
      assign e11 = pool_img_i[elem_idx(2*pr + 1, 2*pc + 1, P_W)*PBW +: PBW];
      assign m0  = (e00 > e01) ? e00 : e01;
      assign m1  = (e10 > e11) ? e10 : e11;
      assign pool_d[elem_idx(pr, pc, P_W/2)*PBW +: PBW] = (m0 > m1) ? m0 : m1;
    end
  end

  for (genvar o = 0; o < FC_OUT; o++) begin : g_fc
    npu_dot #(.N(FC_LEN), .BW(BW), .OW(2 * BW)) u_dot (
      .a   (fc_x_i),
      .b   (fc_w_i[o*FC_LEN*BW +: FC_LEN*BW]),
      .bias(fc_b_i[o*BW +: BW]),
      .y   (fc_d[o*2*BW +: 2*BW])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      conv_o  <= '0;
      pool_o  <= '0;
      fc_o    <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (start_i) begin
        case (op_e'(op_i))
          OP_CONV: begin conv_o <= conv_d; valid_o <= 1'b1; end
          OP_POOL: begin pool_o <= pool_d; valid_o <= 1'b1; end
          OP_FC:   begin fc_o   <= fc_d;   valid_o <= 1'b1; end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_npu_layer_engine.sv
// Bench for npu_layer_engine at reduced size: directed vector table, multi-cycle
// control sequences, then random traffic against an array-based reference model.
module tb_npu_layer_engine;

  localparam int BW = 8, IH = 4, IW = 4, K = 3, PH = 4, PW = 4, PBW = 16, FL = 3, FO = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [1:0]   op;
  logic [127:0] cimg;
  logic [71:0]  cw;
  logic [7:0]   cb;
  logic [255:0] pimg;
  logic [23:0]  fx;
  logic [47:0]  fw;
  logic [15:0]  fb;
  logic [63:0]  conv_o;
  logic [63:0]  pool_o;
  logic [31:0]  fc_o;
  logic         valid_o;

  int checks = 0;
  int errors = 0;

  npu_layer_engine #(
    .BW(BW), .IMG_H(IH), .IMG_W(IW), .K(K), .P_H(PH), .P_W(PW),
    .PBW(PBW), .FC_LEN(FL), .FC_OUT(FO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .op_i(op),
    .conv_img_i(cimg), .conv_w_i(cw), .conv_b_i(cb), .pool_img_i(pimg),
    .fc_x_i(fx), .fc_w_i(fw), .fc_b_i(fb),
    .conv_o(conv_o), .pool_o(pool_o), .fc_o(fc_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         start;
    logic [1:0]   op;
    logic [127:0] cimg;
    logic [71:0]  cw;
    logic [7:0]   cb;
    logic [255:0] pimg;
    logic [23:0]  fx;
    logic [47:0]  fw;
    logic [15:0]  fb;
    logic [63:0]  econv;
    logic [63:0]  epool;
    logic [31:0]  efc;
    logic         evalid;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: unpack to integer arrays, plain arithmetic, wrap to 16 bits at the end.
  function automatic logic [63:0] ref_conv(input logic [127:0] img, input logic [71:0] w,
                                           input logic [7:0] b);
    int im[4][4];
    int f[3][3];
    int acc;
    logic [63:0] res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) im[r][c] = int'($signed(img[(r*4+c)*8 +: 8]));
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) f[i][j] = int'($signed(w[(i*3+j)*8 +: 8]));
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        acc = int'($signed(b));
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) acc += im[r+i][c+j] * f[i][j];
        res[(r*2+c)*16 +: 16] = acc[15:0];
      end
    return res;
  endfunction

  function automatic logic [63:0] ref_pool(input logic [255:0] img);
    int im[4][4];
    int mx;
    logic [63:0] res = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) im[r][c] = int'($signed(img[(r*4+c)*16 +: 16]));
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++) begin
        mx = im[2*r][2*c];
        for (int i = 0; i < 2; i++)
          for (int j = 0; j < 2; j++) if (im[2*r+i][2*c+j] > mx) mx = im[2*r+i][2*c+j];
        res[(r*2+c)*16 +: 16] = mx[15:0];
      end
    return res;
  endfunction

  function automatic logic [31:0] ref_fc(input logic [23:0] x, input logic [47:0] w,
                                         input logic [15:0] b);
    int acc;
    logic [31:0] res = '0;
    for (int o = 0; o < 2; o++) begin
      acc = int'($signed(b[o*8 +: 8]));
      for (int n = 0; n < 3; n++)
        acc += int'($signed(x[n*8 +: 8])) * int'($signed(w[(o*3+n)*8 +: 8]));
      res[o*16 +: 16] = acc[15:0];
    end
    return res;
  endfunction

  function automatic logic [7:0] rand_byte();
    logic [31:0] t;
    t = $urandom;
    case (t[10:8])
      3'd0:    return 8'h80;
      3'd1:    return 8'h7F;
      default: return t[7:0];
    endcase
  endfunction

  task automatic check_all(input string tag, input logic [63:0] ec, input logic [63:0] ep,
                           input logic [31:0] ef, input logic ev);
    chk({tag, ".conv"},  conv_o,          ec);
    chk({tag, ".pool"},  pool_o,          ep);
    chk({tag, ".fc"},    {32'd0, fc_o},   {32'd0, ef});
    chk({tag, ".valid"}, {63'd0, valid_o}, {63'd0, ev});
  endtask

  vec_t tbl[9];
  vec_t v;
  logic [63:0] m_conv, m_pool;
  logic [31:0] m_fc;
  logic        m_valid;

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'd0;
    cimg = '0; cw = '0; cb = '0; pimg = '0; fx = '0; fw = '0; fb = '0;
    #3;
    check_all("reset", '0, '0, '0, 1'b0);

    // Directed table; expectations accumulate because unselected registers hold.
    v = '{default: '0};
    v.start = 1'b1; v.op = 2'd0;
    v.cimg = {16{8'h01}}; v.cw = {9{8'h01}}; v.cb = 8'd2;
    v.econv = {4{16'd11}}; v.evalid = 1'b1;
    tbl[0] = v;
    v.start = 1'b0; v.evalid = 1'b0;
    tbl[1] = v;
    v.start = 1'b1; v.evalid = 1'b1;
    v.cimg = {16{8'hFF}}; v.cw = {9{8'h02}}; v.cb = 8'd0; v.econv = {4{16'hFFEE}};
    tbl[2] = v;
    v.cimg = {16{8'd127}}; v.cw = {9{8'd127}}; v.cb = 8'd127; v.econv = {4{16'h3788}};
    tbl[3] = v;
    v.op = 2'd1;
    for (int i = 0; i < 16; i++) v.pimg[i*16 +: 16] = 16'(i);
    v.epool = {16'd15, 16'd13, 16'd7, 16'd5};
    tbl[4] = v;
    v.pimg = {16{16'hFFFD}}; v.pimg[64 +: 16] = 16'hFFFF;
    v.epool = {16'hFFFD, 16'hFFFD, 16'hFFFD, 16'hFFFF};
    tbl[5] = v;
    v.op = 2'd2;
    v.fx = {8'd3, 8'd2, 8'd1};
    v.fw = {8'd2, 8'd0, 8'hFF, 8'd1, 8'd1, 8'd1};
    v.fb = {8'd5, 8'd0};
    v.efc = {16'd10, 16'd6};
    tbl[6] = v;
    v.op = 2'd3; v.evalid = 1'b0;
    v.cimg = {16{8'h01}}; v.cw = {9{8'h01}}; v.cb = 8'd2; v.pimg = '0; v.fb = '0;
    tbl[7] = v;
    v.start = 1'b0; v.op = 2'd0;
    tbl[8] = v;

    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      start = tbl[i].start; op = tbl[i].op;
      cimg = tbl[i].cimg; cw = tbl[i].cw; cb = tbl[i].cb; pimg = tbl[i].pimg;
      fx = tbl[i].fx; fw = tbl[i].fw; fb = tbl[i].fb;
      @(posedge clk); #1;
      check_all($sformatf("tbl%0d", i), tbl[i].econv, tbl[i].epool, tbl[i].efc, tbl[i].evalid);
    end
    m_conv = tbl[8].econv; m_pool = tbl[8].epool; m_fc = tbl[8].efc;

    // Back-to-back CONV then POOL: valid stays high for two cycles.
    @(negedge clk);
    start = 1'b1; op = 2'd0;
    cimg = {$urandom, $urandom, $urandom, $urandom}; cw = {rand_byte(), 64'h0102_0304_FFFE_8081};
    cb = rand_byte();
    m_conv = ref_conv(cimg, cw, cb);
    @(posedge clk); #1;
    check_all("b2b_conv", m_conv, m_pool, m_fc, 1'b1);
    @(negedge clk);
    op = 2'd1;
    for (int i = 0; i < 8; i++) pimg[i*32 +: 32] = $urandom;
    m_pool = ref_pool(pimg);
    @(posedge clk); #1;
    check_all("b2b_pool", m_conv, m_pool, m_fc, 1'b1);
    @(negedge clk); start = 1'b0;
    @(posedge clk); #1;
    check_all("b2b_idle", m_conv, m_pool, m_fc, 1'b0);

    // Reset between edges while a valid pulse is showing.
    @(negedge clk);
    start = 1'b1; op = 2'd2;
    fx = {rand_byte(), rand_byte(), rand_byte()};
    fw = {rand_byte(), rand_byte(), rand_byte(), rand_byte(), rand_byte(), rand_byte()};
    fb = {rand_byte(), rand_byte()};
    m_fc = ref_fc(fx, fw, fb);
    @(posedge clk); #1;
    check_all("pre_rst", m_conv, m_pool, m_fc, 1'b1);
    #1 rst = 1'b1;
    #1;
    check_all("mid_rst", '0, '0, '0, 1'b0);
    @(negedge clk); start = 1'b0; rst = 1'b0;
    m_conv = '0; m_pool = '0; m_fc = '0;

    // Random traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      start = ($urandom_range(0, 3) != 0);
      op = 2'($urandom_range(0, 3));
      for (int i = 0; i < 16; i++) cimg[i*8 +: 8] = rand_byte();
      for (int i = 0; i < 9; i++) cw[i*8 +: 8] = rand_byte();
      cb = rand_byte();
      for (int i = 0; i < 16; i++) pimg[i*16 +: 16] = {rand_byte(), rand_byte()};
      for (int i = 0; i < 3; i++) fx[i*8 +: 8] = rand_byte();
      for (int i = 0; i < 6; i++) fw[i*8 +: 8] = rand_byte();
      fb = {rand_byte(), rand_byte()};
      m_valid = 1'b0;
      if (start) begin
        case (op)
          2'd0: begin m_conv = ref_conv(cimg, cw, cb); m_valid = 1'b1; end
          2'd1: begin m_pool = ref_pool(pimg);         m_valid = 1'b1; end
          2'd2: begin m_fc   = ref_fc(fx, fw, fb);     m_valid = 1'b1; end
          default: ;
        endcase
      end
      @(posedge clk); #1;
      check_all($sformatf("rnd%0d", n), m_conv, m_pool, m_fc, m_valid);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
